// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: UART receive front end, one instance per rx line.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, stop bit (1), idle high.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined;
// without it parity_error is tied low.
module uart_byte_receiver #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115200
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ack,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  overrun,
   output logic                  parity_error
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned IDX_W        = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_meta_d;
   logic                    rx_s_q, rx_s_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    data_valid_q, data_valid_d;
   logic                    frame_error_q, frame_error_d;
   logic                    overrun_q, overrun_d;
   logic                    accept;
`ifdef UART_RX_PARITY_EN
   logic                    par_bad_q, par_bad_d;
   logic                    parity_error_q, parity_error_d;
`endif

   // Next-state, datapath and one-cycle error pulses
   always_comb begin
      rx_meta_d     = rx;
      rx_s_d        = rx_meta_q;
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      shift_d       = shift_q;
      data_out_d    = data_out_q;
      data_valid_d  = data_valid_q;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;
      accept        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d      = par_bad_q;
      parity_error_d = 1'b0;
`endif
      if (data_valid_q && data_ack) data_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               parity_error_d = ^{shift_q, rx_s_q};
               par_bad_d      = ^{shift_q, rx_s_q};
               state_d        = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  frame_error_d = 1'b1;
                  state_d       = S_BREAK;
               end else begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  accept = !par_bad_q;
`else
                  accept = 1'b1;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A new byte wins over a same-cycle ack; overrun only when the old byte was not taken
      if (accept) begin
         data_out_d   = shift_q;
         data_valid_d = 1'b1;
         overrun_d    = data_valid_q && !data_ack;
      end
   end

   // State and output registers, async reset
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q       <= S_IDLE;
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         cnt_q         <= '0;
         idx_q         <= '0;
         shift_q       <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q      <= 1'b0;
         parity_error_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rx_meta_q     <= rx_meta_d;
         rx_s_q        <= rx_s_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shift_q       <= shift_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q      <= par_bad_d;
         parity_error_q <= parity_error_d;
`endif
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error = parity_error_q;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Testbench for uart_byte_receiver (honours UART_RX_PARITY_EN when defined).
// Reference model works per frame: each sent frame schedules a stop-sample cycle
// from the frame-timing formula; the model applies accept/ack/overrun rules there.
module tb_uart_byte_receiver;

   localparam int unsigned DW           = 8;
   localparam int unsigned CLKS_PER_BIT = 50_000_000 / 115200;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PAR_BITS = 1;
`else
   localparam int unsigned PAR_BITS = 0;
`endif
   // pin fall -> edge that samples the stop bit: 2 sync flops, IDLE->START edge,
   // then half a bit plus the data (and parity) bits and the stop bit
   localparam int unsigned STOP_OFS = 3 + HALF_BIT + (DW + 1 + PAR_BITS) * CLKS_PER_BIT;

   logic          clk, rstN, rx, data_ack;
   logic [DW-1:0] data_out;
   logic          data_valid, busy, frame_error, overrun, parity_error;

   uart_byte_receiver #(
      .DATA_WIDTH (DW),
      .CLK_FREQ   (50_000_000),
      .BAUD_RATE  (115200)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .rx           (rx),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_ack     (data_ack),
      .busy         (busy),
      .frame_error  (frame_error),
      .overrun      (overrun),
      .parity_error (parity_error)
   );

   typedef struct {
      int unsigned par_cyc;
      int unsigned stop_cyc;
      logic [DW-1:0] data;
      bit stop_ok;
      bit par_ok;
   } frame_t;

   frame_t      exp_q[$];
   int unsigned n_checks = 0, n_fail = 0;
   int unsigned cyc = 0;
   int unsigned last_fall = 0, rise_cyc = 0;
   int unsigned rise_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_cnt = 0;
   bit          m_valid = 0, ack_drv = 0, auto_ack = 0, ack_once = 0, last_valid = 0;
   logic [DW-1:0] m_data = '0;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic hold(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] b, input bit stop_bit, input bit par_flip,
                             input int unsigned stop_len);
      frame_t f;
      @(posedge clk);
      #1;
      rx         = 1'b0;
      last_fall  = cyc;
      f.stop_cyc = cyc + STOP_OFS;
      f.par_cyc  = f.stop_cyc - CLKS_PER_BIT;
      f.data     = b;
      f.stop_ok  = stop_bit;
      f.par_ok   = !par_flip;
      exp_q.push_back(f);
      hold(CLKS_PER_BIT);
      for (int i = 0; i < DW; i++) begin
         rx = b[i];
         hold(CLKS_PER_BIT);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      hold(CLKS_PER_BIT);
`endif
      rx = stop_bit;
      hold(stop_len);
      rx = 1'b1;
   endtask

   // Reference model, output comparison and ack driver, once per cycle on the falling edge
   initial begin : model_loop
      frame_t f;
      bit e_fe, e_ov, e_pe, ev, acc;
      logic [11:0] snap, prev_snap;
      prev_snap = '0;
      forever begin
         @(negedge clk);
         snap = {data_valid, data_out, frame_error, overrun, parity_error};
         if (data_valid && !last_valid) begin
            rise_cyc = cyc;
            rise_cnt++;
         end
         last_valid = data_valid;
         if (busy) busy_cnt++;
         if (frame_error) fe_cnt++;
         if (overrun) ov_cnt++;
         if (parity_error) pe_cnt++;
         e_fe = 0; e_ov = 0; e_pe = 0; ev = 0; acc = 0;
         if (!rstN) begin
            m_valid = 0;
            m_data  = '0;
            exp_q.delete();
            ev = 1;
            check("reset_busy", 32'(busy), 32'(0));
         end else begin
`ifdef UART_RX_PARITY_EN
            if (exp_q.size() > 0 && exp_q[0].par_cyc == cyc) begin
               e_pe = !exp_q[0].par_ok;
               ev   = 1;
            end
`endif
            if (exp_q.size() > 0 && exp_q[0].stop_cyc == cyc) begin
               f  = exp_q.pop_front();
               ev = 1;
               if (!f.stop_ok) e_fe = 1;
               else if (f.par_ok) acc = 1;
            end
            if (acc) begin
               e_ov    = m_valid && !ack_drv;
               m_valid = 1;
               m_data  = f.data;
            end else if (m_valid && ack_drv) begin
               m_valid = 0;
               ev      = 1;
            end
         end
         if (ev || snap != prev_snap) begin
            check("data_valid", 32'(data_valid), 32'(m_valid));
            check("data_out", 32'(data_out), 32'(m_data));
            check("frame_error", 32'(frame_error), 32'(e_fe));
            check("overrun", 32'(overrun), 32'(e_ov));
            check("parity_error", 32'(parity_error), 32'(e_pe));
         end
         prev_snap = snap;
         ack_drv   = rstN && ((auto_ack && m_valid && !ack_drv) || ack_once);
         ack_once  = 0;
         data_ack  = ack_drv;
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : scenario
      logic [DW-1:0] b;
      bit pf, sb;
      int unsigned r0, f0;
      rstN = 1'b0; rx = 1'b1; data_ack = 1'b0;
      hold(5);
      check("rst_data_out", 32'(data_out), 32'(0));
      check("rst_data_valid", 32'(data_valid), 32'(0));
      rstN = 1'b1;
      hold(5);

      // single byte with immediate ack
      auto_ack = 1;
      send_frame(8'h2A, 1, 0, CLKS_PER_BIT);
      hold(20);
      check("latency_2A", rise_cyc - last_fall, 32'(3 + HALF_BIT + (DW + 1 + PAR_BITS) * CLKS_PER_BIT));
      check("data_2A", 32'(data_out), 32'h2A);
      check("valid_after_ack", 32'(data_valid), 32'(0));

      // back-to-back: next start bit right after the stop sample
      r0 = rise_cnt;
      send_frame(8'hCC, 1, 0, HALF_BIT + 2);
      send_frame(8'h55, 1, 0, CLKS_PER_BIT);
      hold(20);
      check("b2b_rises", rise_cnt - r0, 32'(2));
      check("b2b_data", 32'(data_out), 32'h55);
      check("b2b_no_fe", 32'(fe_cnt), 32'(0));

      // short low glitch is rejected after half a bit
      busy_cnt = 0; r0 = rise_cnt;
      rx = 1'b0;
      hold(100);
      rx = 1'b1;
      hold(400);
      check("glitch_busy_cycles", busy_cnt, HALF_BIT);
      check("glitch_no_valid", rise_cnt - r0, 32'(0));
      check("glitch_idle", 32'(busy), 32'(0));

      // bad stop bit, line held low, then a good frame
      r0 = rise_cnt; f0 = fe_cnt;
      send_frame(8'hA5, 0, 0, 2000);
      check("break_busy", 32'(busy), 32'(1));
      hold(4);
      check("break_exit", 32'(busy), 32'(0));
      check("break_fe_once", fe_cnt - f0, 32'(1));
      check("break_no_valid", rise_cnt - r0, 32'(0));
      send_frame(8'h3C, 1, 0, CLKS_PER_BIT);
      hold(5);
      check("after_break_data", 32'(data_out), 32'h3C);

      // overrun: two bytes without ack
      auto_ack = 0; f0 = ov_cnt;
      send_frame(8'h11, 1, 0, CLKS_PER_BIT);
      send_frame(8'h22, 1, 0, CLKS_PER_BIT);
      hold(5);
      check("overrun_once", ov_cnt - f0, 32'(1));
      check("overrun_data", 32'(data_out), 32'h22);
      check("overrun_valid", 32'(data_valid), 32'(1));

      // reset during data bit 4, pending byte must be dropped too
      b = 8'h5A;
      rx = 1'b0;
      hold(CLKS_PER_BIT);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         hold(CLKS_PER_BIT);
      end
      rx = b[4];
      hold(CLKS_PER_BIT / 2);
      check("midframe_busy", 32'(busy), 32'(1));
      rstN = 1'b0;
      hold(5);
      check("midreset_valid", 32'(data_valid), 32'(0));
      check("midreset_data", 32'(data_out), 32'(0));
      rx = 1'b1;
      rstN = 1'b1;
      hold(10);
      r0 = rise_cnt; auto_ack = 1;
      send_frame(8'h7E, 1, 0, CLKS_PER_BIT);
      hold(5);
      check("post_reset_rises", rise_cnt - r0, 32'(1));
      check("post_reset_data", 32'(data_out), 32'h7E);

`ifdef UART_RX_PARITY_EN
      r0 = rise_cnt; f0 = pe_cnt;
      send_frame(8'h07, 1, 1, CLKS_PER_BIT);
      hold(5);
      check("parity_bad_pulse", pe_cnt - f0, 32'(1));
      check("parity_bad_no_valid", rise_cnt - r0, 32'(0));
      send_frame(8'h07, 1, 0, CLKS_PER_BIT);
      hold(5);
      check("parity_ok_rises", rise_cnt - r0, 32'(1));
      check("parity_ok_data", 32'(data_out), 32'h07);
`endif

      // randomized frames: byte, stop bit, parity flip, ack policy, gap
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         pf = 0;
`ifdef UART_RX_PARITY_EN
         pf = ($urandom_range(0, 3) == 0);
`endif
         auto_ack = ($urandom_range(0, 1) == 1);
         send_frame(b, sb, pf, CLKS_PER_BIT);
         hold($urandom_range(5, 50));
      end
      hold(20);
      check("final_queue_empty", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- UART receive front end for the external-communication path: deserialises frames arriving on the GPIO rx pins (get-data line and send-ack line) into parallel bytes.
- Hands each byte to the external-com controller over a valid/ack handshake.
- Serial format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), idle high.
- One instance per rx line.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 434 at defaults), derived localparam.
- HALF_BIT, CLKS_PER_BIT/2 (217), derived localparam.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rstN  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_WIDTH  last accepted byte.
- data_valid  out  1  high while data_out holds an unconsumed byte.
- data_ack  in  1  consumer takes the byte.
- busy  out  1  high whenever FSM is not IDLE.
- frame_error  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte arrived while data_valid still high.
- parity_error  out  1  one-cycle pulse; constant 0 unless UART_RX_PARITY_EN is defined.

Behaviour:
- Reset (async assert, sync release):
  - data_out=0, data_valid=0, busy=0, all error pulses=0.
  - Synchroniser flops=1, FSM=IDLE, bit counter=0, clock counter=0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only, so latency is 2 cycles from the pin.
- IDLE: rx_s==0 → START, clk counter cleared.
- START: count 0..HALF_BIT-1; at HALF_BIT-1 sample rx_s.
  - 0 → DATA, counter=0, bit index=0.
  - 1 → IDLE (glitch rejected, no output).
- DATA: count 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 shift rx_s into shift register MSB so the byte ends LSB-first aligned.
  - After bit index DATA_WIDTH-1 → STOP (or PARITY with macro).
- STOP: at CLKS_PER_BIT-1 sample rx_s.
  - 1 → byte accepted; data_out loaded; data_valid=1 next cycle; → IDLE.
  - 0 → frame_error pulse; byte discarded; data_out/data_valid unchanged; → BREAK.
- BREAK: stay until rx_s==1, then → IDLE. A held-low line never produces repeated frames.
- Stop-bit sample timing: HALF_BIT + (DATA_WIDTH+1)*CLKS_PER_BIT clocks after entering START (4123 at defaults). data_valid rises the following cycle.
- Handshake:
  - data_valid stays high until a cycle with data_valid&data_ack; it clears on the next edge.
  - data_ack while data_valid=0 is ignored.
- Overrun: a byte is accepted while data_valid=1 and data_ack=0 in the same cycle.
  - data_out overwritten with the new byte, data_valid stays 1, overrun pulses 1 cycle.
- Simultaneous accept and ack: new byte loaded, data_valid stays 1, no overrun.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample (half stop bit left) is detected normally from IDLE.
- busy=1 in START/DATA/STOP/PARITY/BREAK.
- Reset mid-frame: frame abandoned, all state returns to reset values, no pulses emitted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame carries an even-parity bit after the data bits.
  - PARITY state samples it at CLKS_PER_BIT-1, then → STOP.
  - If XOR(data bits, parity bit)!=0 → parity_error pulse, byte discarded even when the stop bit is good.
  - Stop-bit sample shifts by one CLKS_PER_BIT.
- Not defined: no PARITY state, parity_error tied 0, 10-bit frame.

Test Plan:
- Send 8'h2A at BAUD_TIME_PERIOD=8680 ns/bit → data_valid rises 4124±2 clk after rx falls (+2 sync), data_out=8'h2A; ack next cycle → data_valid=0 one cycle later.
- Send 8'hCC then 8'h55 back-to-back, acking each → two valid periods, data_out 8'hCC then 8'h55, no errors.
- 100-clk low glitch on idle rx → busy high ~HALF_BIT cycles, no data_valid, no errors, returns IDLE.
- Frame 8'hA5 with stop bit forced 0, rx held low 2000 clk then high → single frame_error pulse, data_valid stays 0, busy high until rx returns high; a following 8'h3C is then received correctly.
- Send 8'h11 and 8'h22 without ack → overrun pulses once at the second stop sample, data_out=8'h22, data_valid=1.
- Assert rstN low during bit 4 of a frame, release, send 8'h7E → all outputs 0 during reset, no spurious valid, then data_out=8'h7E. With UART_RX_PARITY_EN: 8'h07 with parity 0 → parity_error, no valid; with parity 1 → accepted.
